// File: rtl/add_sub4.sv
// Registered WIDTH-bit two's-complement adder/subtractor (sel: 0 = add, 1 = subtract).
// Define ADDSUB_OVF_EN to add the registered signed-overflow output ovf.
module add_sub4 #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sel,
`ifdef ADDSUB_OVF_EN
  output logic             ovf,
`endif
  output logic             cout,
  output logic [WIDTH-1:0] sum,
  output logic             zero,
  output logic             out_valid
);

  localparam int unsigned WX = WIDTH + 1;

  logic [WIDTH-1:0] b_x;
  logic [WX-1:0]    full;

  // Subtract reuses the adder as a + ~b + 1.
  always_comb begin
    b_x  = b ^ {WIDTH{sel}};
    full = {1'b0, a} + {1'b0, b_x} + WX'(sel);
  end

`ifdef ADDSUB_OVF_EN
  logic [WIDTH-1:0] low;
  logic             ovf_next;

  // Carry into the MSB comes from the low WIDTH-1 bits plus carry-in.
  always_comb begin
    low      = {1'b0, a[WIDTH-2:0]} + {1'b0, b_x[WIDTH-2:0]} + WIDTH'(sel);
    ovf_next = low[WIDTH-1] ^ full[WIDTH];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if (in_valid) begin
      ovf <= ovf_next;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum       <= '0;
      cout      <= 1'b0;
      zero      <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        sum  <= full[WIDTH-1:0];
        cout <= full[WIDTH];
        zero <= (full[WIDTH-1:0] == '0);
      end
    end
  end

endmodule

// File: tb/tb_add_sub4.sv
// Directed and exhaustive self-checking bench for add_sub4.
module tb_add_sub4;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [3:0] a;
  logic [3:0] b;
  logic       sel;
  logic       cout;
  logic [3:0] sum;
  logic       zero;
  logic       out_valid;
`ifdef ADDSUB_OVF_EN
  logic       ovf;
`endif

  int n_vec = 0;
  int n_err = 0;

  add_sub4 #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .sel       (sel),
`ifdef ADDSUB_OVF_EN
    .ovf       (ovf),
`endif
    .cout      (cout),
    .sum       (sum),
    .zero      (zero),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

`ifdef ADDSUB_OVF_EN
  function automatic logic ovf_model(input logic [3:0] x, input logic [3:0] y, input logic s);
    int sx, sy, r;
    sx = (x > 7) ? int'(x) - 16 : int'(x);
    sy = (y > 7) ? int'(y) - 16 : int'(y);
    r  = s ? sx - sy : sx + sy;
    return (r > 7) || (r < -8);
  endfunction
`endif

  // Drive one valid vector, then check the registered result one clock later.
  task automatic vec(input string tag, input logic [3:0] va, input logic [3:0] vb,
                     input logic vs, input logic [3:0] es, input logic ec);
    a = va; b = vb; sel = vs; in_valid = 1'b1;
    @(posedge clk); #1;
    check({tag, ".sum"}, 32'(sum), 32'(es));
    check({tag, ".cout"}, 32'(cout), 32'(ec));
    check({tag, ".zero"}, 32'(zero), 32'(es == 4'd0));
    check({tag, ".vld"}, 32'(out_valid), 32'd1);
`ifdef ADDSUB_OVF_EN
    check({tag, ".ovf"}, 32'(ovf), 32'(ovf_model(va, vb, vs)));
`endif
  endtask

  initial begin
    int n_pulse;
    logic [3:0] xa, xb, es;
    logic       xs, ec;
    clk = 1'b0; rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; sel = 1'b0;
    #1;
    check("rst.sum", 32'(sum), 32'd0);
    check("rst.cout", 32'(cout), 32'd0);
    check("rst.zero", 32'(zero), 32'd1);
    check("rst.vld", 32'(out_valid), 32'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    vec("add5+1", 4'd5, 4'd1, 1'b0, 4'd6, 1'b0);
    vec("add0+0", 4'd0, 4'd0, 1'b0, 4'd0, 1'b0);
    vec("add2+2", 4'd2, 4'd2, 1'b0, 4'd4, 1'b0);
    vec("add1+5", 4'd1, 4'd5, 1'b0, 4'd6, 1'b0);
    vec("sub5-1", 4'd5, 4'd1, 1'b1, 4'd4, 1'b1);
    vec("sub0-0", 4'd0, 4'd0, 1'b1, 4'd0, 1'b1);
    vec("sub2-2", 4'd2, 4'd2, 1'b1, 4'd0, 1'b1);
    vec("sub1-5", 4'd1, 4'd5, 1'b1, 4'd12, 1'b0);
    vec("wrap15+1", 4'd15, 4'd1, 1'b0, 4'd0, 1'b1);
    vec("wrap0-1", 4'd0, 4'd1, 1'b1, 4'd15, 1'b0);
    vec("ovf7+1", 4'd7, 4'd1, 1'b0, 4'd8, 1'b0);
    vec("ovf8-1", 4'd8, 4'd1, 1'b1, 4'd7, 1'b1);

    // Three back-to-back valids, then two idle cycles with garbage inputs.
    n_pulse = 0;
    vec("hs0", 4'd3, 4'd4, 1'b0, 4'd7, 1'b0);
    vec("hs1", 4'd9, 4'd2, 1'b1, 4'd7, 1'b1);
    vec("hs2", 4'd6, 4'd9, 1'b0, 4'd15, 1'b0);
    n_pulse = 3;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b0; a = 4'($urandom); b = 4'($urandom); sel = 1'($urandom);
      @(posedge clk); #1;
      if (out_valid) n_pulse++;
      check("idle.sum", 32'(sum), 32'd15);
      check("idle.cout", 32'(cout), 32'd0);
      check("idle.zero", 32'(zero), 32'd0);
    end
    check("hs.pulses", 32'(n_pulse), 32'd3);

    // Asynchronous reset mid-cycle, with a valid input presented during reset.
    vec("pre_rst", 4'd4, 4'd4, 1'b0, 4'd8, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("arst.sum", 32'(sum), 32'd0);
    check("arst.cout", 32'(cout), 32'd0);
    check("arst.zero", 32'(zero), 32'd1);
    check("arst.vld", 32'(out_valid), 32'd0);
    a = 4'd3; b = 4'd3; sel = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    check("inrst.sum", 32'(sum), 32'd0);
    check("inrst.vld", 32'(out_valid), 32'd0);
    rst = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1;
    check("post_rst.vld", 32'(out_valid), 32'd0);
    check("post_rst.sum", 32'(sum), 32'd0);

    // Exhaustive sweep against an integer reference.
    for (int i = 0; i < 512; i++) begin
      xa = 4'(i); xb = 4'(i >> 4); xs = 1'(i >> 8);
      if (xs) begin
        es = 4'((int'(xa) - int'(xb)) & 15);
        ec = (xa >= xb);
      end else begin
        es = 4'((int'(xa) + int'(xb)) & 15);
        ec = (int'(xa) + int'(xb)) > 15;
      end
      vec("exh", xa, xb, xs, es, ec);
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("end.vld", 32'(out_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/add_sub4.md
Name: add_sub4

Overview:
- 4-bit two's-complement adder/subtractor with a registered result stage.
- `sel` chooses the operation: 0 = add, 1 = subtract.
- Result and carry are captured one clock after a valid input.
- Used as a small arithmetic leaf in datapath and lab designs. It has no internal state beyond the output register.

Parameters:
- WIDTH, 4, operand and result width in bits; must be ≥ 2.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous reset, active-high.
- in_valid  input  1  qualifies a, b and sel this cycle.
- a  input  WIDTH  operand A (minuend in subtract mode).
- b  input  WIDTH  operand B (subtrahend in subtract mode).
- sel  input  1  0 = a+b, 1 = a−b.
- cout  output  1  registered carry-out of the adder.
- sum  output  WIDTH  registered result, modulo 2^WIDTH.
- zero  output  1  registered flag, 1 when sum == 0.
- out_valid  output  1  high for one cycle when sum, cout and zero hold a new result.

Behaviour:
- Core is a single ripple/carry-chain adder.
  - Operand B path: b XOR {WIDTH{sel}}.
  - Carry-in: sel.
  - So subtract is computed as a + ~b + 1.
- {cout, sum_next} = a + (b ^ {WIDTH{sel}}) + sel, computed at WIDTH+1 bits.
- Add mode (sel=0):
  - cout = unsigned carry.
  - {cout,sum} equals the unsigned sum a+b.
- Subtract mode (sel=1):
  - cout = NOT borrow: 1 when a ≥ b unsigned, 0 when a < b.
  - sum = (a − b) mod 2^WIDTH.
- Latency is 1 clock.
  - On a rising clk with in_valid=1: sum, cout and zero load the new result, and out_valid=1.
- On a rising clk with in_valid=0:
  - sum, cout and zero hold their previous values.
  - out_valid=0.
- out_valid is a pulse per accepted input. Back-to-back valid inputs give back-to-back results. There is no backpressure.
- Reset:
  - While rst=1, independent of clk: sum=0, cout=0, zero=1, out_valid=0.
  - Deasserting rst mid-stream discards any input sampled during reset. The first result appears one clock after the first in_valid cycle following release.
- Unknown or don't-care inputs when in_valid=0 have no effect on outputs.
- No saturation. All wrap-around is modulo 2^WIDTH.

Optional Feature:
- Macro ADDSUB_OVF_EN.
- When defined:
  - Adds output port `ovf` (1 bit, registered, same timing as sum).
  - ovf = signed two's-complement overflow = carry into MSB XOR carry out of MSB.
  - ovf resets to 0 and holds when in_valid=0.
- When undefined: port `ovf` and its logic are absent. All other behaviour is identical.

Test Plan:
- Reset: assert rst asynchronously mid-cycle → sum=0, cout=0, zero=1, out_valid=0 immediately, without waiting for a clock edge.
- Add vectors, one cycle after each in_valid=1, sel=0:
  - a=5, b=1 → sum=6, cout=0.
  - a=0, b=0 → sum=0, cout=0, zero=1.
  - a=2, b=2 → sum=4, cout=0.
  - a=1, b=5 → sum=6, cout=0.
- Subtract vectors, sel=1:
  - a=5, b=1 → sum=4, cout=1.
  - a=0, b=0 → sum=0, cout=1, zero=1.
  - a=2, b=2 → sum=0, cout=1.
  - a=1, b=5 → sum=12 (0xC), cout=0.
- Wrap/boundary:
  - a=15, b=1, sel=0 → sum=0, cout=1, zero=1.
  - a=0, b=1, sel=1 → sum=15, cout=0.
  - With ADDSUB_OVF_EN: a=7, b=1, sel=0 → ovf=1; a=8, b=1, sel=1 → ovf=1.
- Handshake:
  - Valid for 3 consecutive cycles, then in_valid=0 for 2 → out_valid high for exactly 3 cycles.
  - Outputs hold the third result during the idle cycles.
- Exhaustive: all 512 combinations of a, b, sel → {cout,sum} matches the reference model above every cycle.
